// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and types for the reorder buffer.
//   ROB_SIZE       - index width; the buffer holds ROB_DEPTH = 2**ROB_SIZE entries
//   ROB_ENTRY_SIZE - opaque dispatch payload width, returned unchanged at retire
//   rob_entry_t    - one buffer entry {valid, done, mispred, payload}
//   ret_slot_t     - one registered retire slot {v, idx, payload}
package rob_pkg;

   localparam int ROB_SIZE       = 7;
   localparam int ROB_ENTRY_SIZE = 44;
   localparam int ROB_DEPTH      = 2 ** ROB_SIZE;

   typedef logic [ROB_SIZE-1:0]       rob_idx_t;
   typedef logic [ROB_SIZE:0]         rob_cnt_t;
   typedef logic [ROB_ENTRY_SIZE-1:0] rob_payload_t;

   typedef struct packed {
      logic         valid;
      logic         done;
      logic         mispred;
      rob_payload_t payload;
   } rob_entry_t;

   typedef struct packed {
      logic         v;
      rob_idx_t     idx;
      rob_payload_t payload;
   } ret_slot_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch channel between the decoder and the reorder buffer.
//   ROB_V1/ROB_V2   - dispatch valid (slot 1 is older)        decoder -> ROB
//   ROB_1/ROB_2     - dispatch payloads                        decoder -> ROB
//   ROB_idx_1/_2    - indices the two slots would be given     ROB -> decoder
//   rob_stall       - fewer than two free entries              ROB -> decoder
// Modports: master = decoder side, slave = reorder buffer side.
interface reorder_buffer_if;
   import rob_pkg::*;

   logic         ROB_V1;
   logic         ROB_V2;
   rob_payload_t ROB_1;
   rob_payload_t ROB_2;
   rob_idx_t     ROB_idx_1;
   rob_idx_t     ROB_idx_2;
   logic         rob_stall;

   modport master (
      output ROB_V1, ROB_V2, ROB_1, ROB_2,
      input  ROB_idx_1, ROB_idx_2, rob_stall
   );

   modport slave (
      input  ROB_V1, ROB_V2, ROB_1, ROB_2,
      output ROB_idx_1, ROB_idx_2, rob_stall
   );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail/count bookkeeping for the reorder buffer.
//   clk, reset - clock and synchronous active-high reset
//   clear      - flush or mispredict clear; returns all pointers to zero
//   disp_n     - number of entries dispatched this cycle (0..2)
//   ret_n      - number of entries retired this cycle (0..2)
//   head, tail - ROB_SIZE-bit pointers, wrap modulo depth
//   count      - occupancy, ROB_SIZE+1 bits so a full buffer is representable
//   rob_stall  - fewer than two free entries
module rob_ptr_ctrl
   import rob_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [1:0] disp_n,
   input  logic [1:0] ret_n,
   output rob_idx_t   head,
   output rob_idx_t   tail,
   output rob_cnt_t   count,
   output logic       rob_stall
);

   rob_idx_t head_reg, head_next;
   rob_idx_t tail_reg, tail_next;
   rob_cnt_t count_reg, count_next;

   // Pointer arithmetic is naturally modulo depth because of the index width.
   always_comb begin
      head_next  = head_reg + rob_idx_t'(ret_n);
      tail_next  = tail_reg + rob_idx_t'(disp_n);
      count_next = count_reg + rob_cnt_t'(disp_n) - rob_cnt_t'(ret_n);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign head      = head_reg;
   assign tail      = tail_reg;
   assign count     = count_reg;
   // Worst case dispatch is two entries, so stall as soon as fewer than two are free.
   assign rob_stall = (count_reg > rob_cnt_t'(ROB_DEPTH - 2));

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue for the dual-issue core.
//   clk, reset          - clock, synchronous active-high reset
//   stall               - blocks dispatch and retirement (completions still land)
//   flush               - clears every entry on the next edge
//   disp                - dispatch channel (reorder_buffer_if.slave)
//   ALU1/ALU2/LS_C_*    - completion valid + index; ALU ports also carry mispred
//   RET_V*/RET_*/RET_idx_* - registered retire slots, slot 1 older
//   rob_flush_out       - registered pulse when a mispredicted branch retires
//   rob_count           - occupancy
// Build option: define ROB_DUAL_RETIRE_EN for two retire slots; otherwise at
// most one entry retires per cycle and RET_V2 stays 0.
module reorder_buffer
   import rob_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   reorder_buffer_if.slave  disp,
   input  logic             ALU1_C_V,
   input  rob_idx_t         ALU1_C_idx,
   input  logic             ALU1_mispred,
   input  logic             ALU2_C_V,
   input  rob_idx_t         ALU2_C_idx,
   input  logic             ALU2_mispred,
   input  logic             LS_C_V,
   input  rob_idx_t         LS_C_idx,
   output logic             RET_V1,
   output logic             RET_V2,
   output rob_payload_t     RET_1,
   output rob_payload_t     RET_2,
   output rob_idx_t         RET_idx_1,
   output rob_idx_t         RET_idx_2,
   output logic             rob_flush_out,
   output rob_cnt_t         rob_count
);

   rob_entry_t entries_reg [ROB_DEPTH];

   rob_idx_t  head, tail, head_p1, tail_p1;
   rob_cnt_t  count;
   logic      rob_stall;
   logic      flush_out_reg, flush_next;
   logic      clear_all;
   logic      disp_ok;
   logic [1:0] disp_n, ret_n;
   logic      ret1, ret2, mp1_retire, mp2_retire;
   rob_entry_t e0;
   rob_payload_t p2;
   ret_slot_t ret1_reg, ret1_next, ret2_reg, ret2_next;

   logic [ROB_DEPTH-1:0] wr1_vec, wr2_vec, ret_clr_vec, cmp_done_vec, cmp_mp_vec;

   // The cycle after a mispredicted branch retires, everything is discarded
   // exactly as for an external flush.
   assign clear_all = flush || flush_out_reg;

   rob_ptr_ctrl u_ptr (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_all),
      .disp_n    (disp_n),
      .ret_n     (ret_n),
      .head      (head),
      .tail      (tail),
      .count     (count),
      .rob_stall (rob_stall)
   );

   assign head_p1 = head + rob_idx_t'(1);
   assign tail_p1 = tail + rob_idx_t'(1);

   // V2 is only honoured together with V1.
   assign disp_ok = !stall && !rob_stall && !clear_all;
   assign disp_n  = (disp_ok && disp.ROB_V1) ? (disp.ROB_V2 ? 2'd2 : 2'd1) : 2'd0;

   assign disp.ROB_idx_1 = tail;
   assign disp.ROB_idx_2 = tail_p1;
   assign disp.rob_stall = rob_stall;

   // Retire selection from the state after the last edge.
   assign e0         = entries_reg[head];
   assign ret1       = !stall && !clear_all && e0.valid && e0.done;
   assign mp1_retire = ret1 && e0.mispred;

`ifdef ROB_DUAL_RETIRE_EN
   rob_entry_t e1;
   assign e1         = entries_reg[head_p1];
   // A mispredicted head ends the stream, so nothing may retire behind it.
   assign ret2       = ret1 && e1.valid && e1.done && !e0.mispred;
   assign mp2_retire = ret2 && e1.mispred;
   assign p2         = e1.payload;
`else
   assign ret2       = 1'b0;
   assign mp2_retire = 1'b0;
   assign p2         = '0;
`endif

   assign ret_n      = {1'b0, ret1} + {1'b0, ret2};
   assign flush_next = mp1_retire || mp2_retire;

   always_comb begin
      ret1_next = '0;
      ret2_next = '0;
      if (ret1) begin
         ret1_next.v       = 1'b1;
         ret1_next.idx     = head;
         ret1_next.payload = e0.payload;
      end
      if (ret2) begin
         ret2_next.v       = 1'b1;
         ret2_next.idx     = head_p1;
         ret2_next.payload = p2;
      end
   end

   // Per-entry decode of dispatch writes, retire clears and completions.
   // Completions are merged per entry so two ports hitting the same index
   // OR their mispred bits instead of one overwriting the other.
   generate
      for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
         logic hit_a1, hit_a2, hit_ls;
         assign hit_a1 = ALU1_C_V && (ALU1_C_idx == rob_idx_t'(gi));
         assign hit_a2 = ALU2_C_V && (ALU2_C_idx == rob_idx_t'(gi));
         assign hit_ls = LS_C_V   && (LS_C_idx   == rob_idx_t'(gi));

         assign wr1_vec[gi]      = (disp_n != 2'd0) && (tail == rob_idx_t'(gi));
         assign wr2_vec[gi]      = (disp_n == 2'd2) && (tail_p1 == rob_idx_t'(gi));
         assign ret_clr_vec[gi]  = (ret1 && (head == rob_idx_t'(gi))) ||
                                   (ret2 && (head_p1 == rob_idx_t'(gi)));
         assign cmp_done_vec[gi] = entries_reg[gi].valid && (hit_a1 || hit_a2 || hit_ls);
         assign cmp_mp_vec[gi]   = (hit_a1 && ALU1_mispred) || (hit_a2 && ALU2_mispred);
      end
   endgenerate

   // Payloads are not reset; they are only observed behind a valid bit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
         if (reset || clear_all) begin
            entries_reg[i].valid   <= 1'b0;
            entries_reg[i].done    <= 1'b0;
            entries_reg[i].mispred <= 1'b0;
         end else if (wr1_vec[i]) begin
            entries_reg[i] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0, payload: disp.ROB_1};
         end else if (wr2_vec[i]) begin
            entries_reg[i] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0, payload: disp.ROB_2};
         end else if (ret_clr_vec[i]) begin
            entries_reg[i].valid   <= 1'b0;
            entries_reg[i].done    <= 1'b0;
            entries_reg[i].mispred <= 1'b0;
         end else if (cmp_done_vec[i]) begin
            entries_reg[i].done    <= 1'b1;
            entries_reg[i].mispred <= entries_reg[i].mispred | cmp_mp_vec[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear_all) begin
         ret1_reg      <= '0;
         ret2_reg      <= '0;
         flush_out_reg <= 1'b0;
      end else begin
         ret1_reg      <= ret1_next;
         ret2_reg      <= ret2_next;
         flush_out_reg <= flush_next;
      end
   end

   assign RET_V1        = ret1_reg.v;
   assign RET_idx_1     = ret1_reg.idx;
   assign RET_1         = ret1_reg.payload;
   assign RET_V2        = ret2_reg.v;
   assign RET_idx_2     = ret2_reg.idx;
   assign RET_2         = ret2_reg.payload;
   assign rob_flush_out = flush_out_reg;
   assign rob_count     = count;

   // Slot 2 without slot 1 is a decoder protocol error.
   v2_without_v1 : assert property (@(posedge clk) disable iff (reset)
                                    !(disp.ROB_V2 && !disp.ROB_V1));

endmodule
